// File: rtl/alarm_pkg.sv
// Shared alarm definitions: state encodings, event counter width, saturating increment.
package alarm_pkg;
  localparam logic [1:0] ST_IDLE     = 2'b00;
  localparam logic [1:0] ST_PENDING  = 2'b01;
  localparam logic [1:0] ST_SOUNDING = 2'b10;
  localparam logic [1:0] ST_HOLDOFF  = 2'b11;

  localparam int EVT_W = 8;

  typedef logic [1:0] state_t;

  function automatic logic [EVT_W-1:0] sat_inc(input logic [EVT_W-1:0] v);
    return (v == {EVT_W{1'b1}}) ? v : v + 1'b1;
  endfunction
endpackage

// File: rtl/alarm_tick_gen.sv
// Timer prescaler: counts 0..DIV-1 and flags the last count as a one-cycle tick.
module alarm_tick_gen #(
  parameter int unsigned DIV = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);
  localparam int PW = $clog2(DIV);
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  logic [PW-1:0] pre_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      pre_q <= '0;
    else if (clr || pre_q == LAST)   pre_q <= '0;
    else                             pre_q <= pre_q + 1'b1;
  end

  assign tick = (pre_q == LAST);
endmodule

// File: rtl/alarm_siren_ctrl.sv
// Alarm siren sequencer: entry delay, bounded siren, hold-off, disarm, event count.
// Optional flashing beacon enabled by defining ALARM_STROBE_EN.
module alarm_siren_ctrl
  import alarm_pkg::*;
#(
  parameter logic [15:0] TICK_DIV    = 16'd50000,
  parameter logic [7:0]  ENTRY_TICKS = 8'd30,
  parameter logic [7:0]  SIREN_TICKS = 8'd180
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             ALARM,
  input  logic             PANIC,
  input  logic             ENABLE,
  input  logic             DISARM,
  output logic             SIREN,
  output logic             STROBE,
  output logic [1:0]       STATE,
  output logic [EVT_W-1:0] EVENT_CNT
);
  state_t           state_q, state_d;
  logic             tick, entry, expiry;
  logic [7:0]       tcnt_q, tlast;
  logic [EVT_W-1:0] evcnt_q;

  assign tlast  = (state_q == ST_PENDING) ? ENTRY_TICKS - 8'd1 : SIREN_TICKS - 8'd1;
  assign expiry = tick && (tcnt_q == tlast) &&
                  (state_q == ST_PENDING || state_q == ST_SOUNDING);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (PANIC)                state_d = ST_SOUNDING;
        else if (ENABLE && ALARM) state_d = ST_PENDING;
      end
      ST_PENDING: begin
        if (PANIC)       state_d = ST_SOUNDING;
        else if (DISARM) state_d = ST_IDLE;
        else if (expiry) state_d = ST_SOUNDING;
      end
      ST_SOUNDING: begin
        // Held PANIC keeps the siren going: it outranks both DISARM and expiry.
        if (PANIC)       state_d = ST_SOUNDING;
        else if (DISARM) state_d = ST_IDLE;
        else if (expiry) state_d = ST_HOLDOFF;
      end
      default: begin
        if (PANIC)        state_d = ST_HOLDOFF;
        else if (DISARM)  state_d = ST_IDLE;
        else if (!ALARM)  state_d = ST_IDLE;
      end
    endcase
  end

  assign entry = (state_d != state_q);

  alarm_tick_gen #(.DIV(int'(TICK_DIV))) u_tick (
    .clk   (CLK),
    .rst_n (RST_N),
    .clr   (entry),
    .tick  (tick)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      tcnt_q  <= '0;
      evcnt_q <= '0;
    end else begin
      state_q <= state_d;
      // Tick counter parks at its last value so a PANIC-extended siren cannot wrap it.
      if (entry)                       tcnt_q <= '0;
      else if (tick && tcnt_q != tlast) tcnt_q <= tcnt_q + 8'd1;
      if (entry && state_d == ST_SOUNDING) evcnt_q <= sat_inc(evcnt_q);
    end
  end

  assign STATE     = state_q;
  assign SIREN     = (state_q == ST_SOUNDING);
  assign EVENT_CNT = evcnt_q;

`ifdef ALARM_STROBE_EN
  logic strobe_q;
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)                      strobe_q <= 1'b0;
    else if (state_d != ST_SOUNDING) strobe_q <= 1'b0;
    else if (entry)                  strobe_q <= 1'b1;
    else if (tick)                   strobe_q <= ~strobe_q;
  end
  assign STROBE = strobe_q;
`else
  assign STROBE = 1'b0;
`endif
endmodule

// File: tb/tb_alarm_siren_ctrl.sv
// Directed bench for alarm_siren_ctrl with TICK_DIV=4, ENTRY_TICKS=3, SIREN_TICKS=5.
module tb_alarm_siren_ctrl;
  localparam logic [1:0] I = 2'b00, P = 2'b01, S = 2'b10, H = 2'b11;

  logic       CLK = 1'b0, RST_N = 1'b0;
  logic       ALARM = 1'b0, PANIC = 1'b0, ENABLE = 1'b0, DISARM = 1'b0;
  logic       SIREN, STROBE;
  logic [1:0] STATE;
  logic [7:0] EVENT_CNT;

  int checks = 0, errors = 0;
  int snd_k = 0;
  logic [1:0] prev_st = I;

  typedef struct {
    string      tag;
    logic [1:0] st;
    logic       siren;
    logic       strobe;
    logic [7:0] ev;
  } exp_t;
  exp_t sb[$];

  alarm_siren_ctrl #(.TICK_DIV(16'd4), .ENTRY_TICKS(8'd3), .SIREN_TICKS(8'd5)) dut (
    .CLK(CLK), .RST_N(RST_N), .ALARM(ALARM), .PANIC(PANIC), .ENABLE(ENABLE),
    .DISARM(DISARM), .SIREN(SIREN), .STROBE(STROBE), .STATE(STATE), .EVENT_CNT(EVENT_CNT)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Queue the expectation for the current sample point; strobe follows a 4-cycle
  // half-period counted from SOUNDING entry.
  task automatic push(input string tag, input logic [1:0] st, input logic [7:0] ev);
    exp_t e;
    logic sb_exp;
    if (st == S) snd_k = (prev_st == S) ? snd_k + 1 : 0;
    prev_st = st;
`ifdef ALARM_STROBE_EN
    sb_exp = (st == S) && (((snd_k / 4) % 2) == 0);
`else
    sb_exp = 1'b0;
`endif
    e.tag = tag; e.st = st; e.siren = (st == S); e.strobe = sb_exp; e.ev = ev;
    sb.push_back(e);
  endtask

  task automatic compare();
    exp_t e;
    e = sb.pop_front();
    checks++;
    assert (STATE === e.st) else begin
      errors++; $error("FAIL %s STATE got %b exp %b", e.tag, STATE, e.st);
    end
    checks++;
    assert (SIREN === e.siren) else begin
      errors++; $error("FAIL %s SIREN got %b exp %b", e.tag, SIREN, e.siren);
    end
    checks++;
    assert (STROBE === e.strobe) else begin
      errors++; $error("FAIL %s STROBE got %b exp %b", e.tag, STROBE, e.strobe);
    end
    checks++;
    assert (EVENT_CNT === e.ev) else begin
      errors++; $error("FAIL %s EVENT_CNT got %0d exp %0d", e.tag, EVENT_CNT, e.ev);
    end
  endtask

  task automatic step(input string tag, input logic [1:0] st, input logic [7:0] ev);
    push(tag, st, ev);
    @(posedge CLK);
    #1;
    compare();
  endtask

  task automatic steps(input int n, input string tag, input logic [1:0] st, input logic [7:0] ev);
    for (int i = 0; i < n; i++) step(tag, st, ev);
  endtask

  initial begin
    int ev;
    repeat (2) @(posedge CLK);
    #1;
    push("reset", I, 8'd0); compare();
    RST_N = 1'b1;
    step("idle", I, 8'd0);

    // Entry delay, siren, hold-off from a one-cycle ALARM pulse
    ENABLE = 1'b1; ALARM = 1'b1;
    step("t2_enter_pend", P, 8'd0);
    ALARM = 1'b0;
    steps(11, "t2_pend", P, 8'd0);
    step("t2_enter_snd", S, 8'd1);
    steps(19, "t2_snd", S, 8'd1);
    step("t2_holdoff", H, 8'd1);
    step("t2_idle", I, 8'd1);

    // DISARM during entry delay
    ALARM = 1'b1;
    step("t3_pend", P, 8'd1);
    ALARM = 1'b0;
    steps(4, "t3_pend_wait", P, 8'd1);
    DISARM = 1'b1;
    step("t3_disarm", I, 8'd1);
    DISARM = 1'b0;
    step("t3_idle", I, 8'd1);

    // PANIC while disarmed, DISARM ignored until PANIC drops
    ENABLE = 1'b0; PANIC = 1'b1;
    step("t4_panic", S, 8'd2);
    DISARM = 1'b1;
    step("t4_disarm_ign", S, 8'd2);
    DISARM = 1'b0;
    step("t4_hold", S, 8'd2);
    PANIC = 1'b0; DISARM = 1'b1;
    step("t4_disarm", I, 8'd2);
    DISARM = 1'b0;

    // ALARM held through siren keeps HOLDOFF
    ENABLE = 1'b1; ALARM = 1'b1;
    step("t5_pend", P, 8'd2);
    steps(11, "t5_pend_wait", P, 8'd2);
    step("t5_snd", S, 8'd3);
    steps(19, "t5_snd_wait", S, 8'd3);
    step("t5_holdoff", H, 8'd3);
    steps(3, "t5_holdoff_stay", H, 8'd3);
    ALARM = 1'b0;
    step("t5_clear", I, 8'd3);

    // DISARM on the exact expiry edge wins
    ALARM = 1'b1;
    step("t5_pend2", P, 8'd3);
    ALARM = 1'b0;
    steps(11, "t5_pend2_wait", P, 8'd3);
    DISARM = 1'b1;
    step("t5_disarm_expiry", I, 8'd3);
    DISARM = 1'b0;
    step("t5_idle", I, 8'd3);

    // Event counter saturation
    ENABLE = 1'b0;
    ev = 3;
    for (int i = 0; i < 300; i++) begin
      ev = (ev < 255) ? ev + 1 : 255;
      PANIC = 1'b1;
      step("t6_panic", S, 8'(ev));
      PANIC = 1'b0; DISARM = 1'b1;
      step("t6_disarm", I, 8'(ev));
      DISARM = 1'b0;
    end

    // Full siren run at saturation exercises the strobe pattern
    PANIC = 1'b1;
    step("t6_snd", S, 8'hFF);
    PANIC = 1'b0;
    steps(19, "t6_strobe", S, 8'hFF);
    step("t6_holdoff", H, 8'hFF);
    step("t6_idle", I, 8'hFF);

    // Asynchronous reset mid-SOUNDING
    PANIC = 1'b1;
    step("t1_snd", S, 8'hFF);
    PANIC = 1'b0;
    step("t1_snd2", S, 8'hFF);
    #2;
    RST_N = 1'b0;
    #1;
    push("t1_async_reset", I, 8'd0); compare();
    @(negedge CLK);
    RST_N = 1'b1;
    step("t1_after_reset", I, 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
